// File: rtl/brick_game_pkg.sv
// Shared types and constants for the brick-breaker game sequencer.
// The PAUSE state code is defined here but is only ever entered when the
// design is built with PAUSE_EN.
package brick_game_pkg;

  localparam int NUM_BRICKS = 56;
  localparam int LIVES_W    = 2;
  localparam int LEVEL_W    = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_MISS  = 3'd3,
    ST_CLEAR = 3'd4,
    ST_OVER  = 3'd5,
    ST_PAUSE = 3'd6
  } game_state_e;

  // Ball step divisor for a level: the base divisor halves per level and
  // never drops below one cycle per step.
  function automatic int unsigned step_div(input int unsigned tick_div,
                                           input logic [LEVEL_W-1:0] lvl);
    int unsigned d;
    d = tick_div >> lvl;
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/brick_game_ctrl_step_divider.sv
// Ball-advance divider: counts enabled cycles and emits a one-cycle tick
// on the last count of each period. The count freezes while disabled and
// is zeroed by clear.
module step_divider #(
  parameter int DIV_W = 25
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] count_q;
  logic [DIV_W-1:0] count_d;
  logic             at_end;

  // Terminal-count detect and next count; >= keeps the counter from running
  // the long way round should div ever shrink below the live count.
  always_comb begin
    at_end  = (count_q >= (div - DIV_W'(1)));
    tick    = enable && at_end;
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = at_end ? '0 : (count_q + DIV_W'(1));
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/brick_game_ctrl.sv
// Top-level game sequencer for the brick-breaker: game FSM, lives and level
// counters, button edge detection and the ball step divider.
// Build option: define PAUSE_EN to add pause_btn and the PAUSE state.
module brick_game_ctrl
  import brick_game_pkg::*;
#(
  parameter int TICK_DIV  = 25000000,
  parameter int LIVES     = 3,
  parameter int MAX_LEVEL = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start_btn,
  input  logic                  launch_btn,
`ifdef PAUSE_EN
  input  logic                  pause_btn,
`endif
  input  logic [NUM_BRICKS-1:0] bricks,
  input  logic                  ball_lost,
  output logic                  step_tick,
  output logic                  bricks_reload,
  output logic                  ball_serve,
  output logic [LIVES_W-1:0]    lives,
  output logic [LEVEL_W-1:0]    level,
  output logic [2:0]            state,
  output logic                  game_over
);

  localparam int DIV_W = $clog2(TICK_DIV + 1);

  game_state_e        state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               reload_q, reload_d;
  logic               serve_q, serve_d;
  logic               start_prev_q, start_prev_d;
  logic               launch_prev_q, launch_prev_d;
  logic               start_edge;
  logic               launch_edge;
  logic               pause_edge;
  logic               div_en;
  logic               div_clr;
  logic [DIV_W-1:0]   div_val;

`ifdef PAUSE_EN
  logic               pause_prev_q, pause_prev_d;
`endif

  // Button rising edges against last cycle's sampled level.
  always_comb begin
    start_edge    = start_btn && !start_prev_q;
    launch_edge   = launch_btn && !launch_prev_q;
    start_prev_d  = start_btn;
    launch_prev_d = launch_btn;
`ifdef PAUSE_EN
    pause_edge    = pause_btn && !pause_prev_q;
    pause_prev_d  = pause_btn;
`else
    pause_edge    = 1'b0;
`endif
  end

  // State, counters, pulse and edge registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      lives_q       <= LIVES_W'(LIVES);
      level_q       <= '0;
      reload_q      <= 1'b0;
      serve_q       <= 1'b0;
      start_prev_q  <= 1'b0;
      launch_prev_q <= 1'b0;
`ifdef PAUSE_EN
      pause_prev_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      level_q       <= level_d;
      reload_q      <= reload_d;
      serve_q       <= serve_d;
      start_prev_q  <= start_prev_d;
      launch_prev_q <= launch_prev_d;
`ifdef PAUSE_EN
      pause_prev_q  <= pause_prev_d;
`endif
    end
  end

  // Next-state logic; a cleared field beats a simultaneous lost ball.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) state_d = ST_SERVE;
      end
      ST_SERVE: begin
        if (launch_edge) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (bricks == '0) begin
          state_d = ST_CLEAR;
        end else if (ball_lost) begin
          state_d = ST_MISS;
        end else if (pause_edge) begin
`ifdef PAUSE_EN
          state_d = ST_PAUSE;
`else
          state_d = ST_PLAY;
`endif
        end
      end
      ST_MISS: begin
        state_d = (lives_q <= LIVES_W'(1)) ? ST_OVER : ST_SERVE;
      end
      ST_CLEAR: begin
        state_d = ST_SERVE;
      end
`ifdef PAUSE_EN
      ST_PAUSE: begin
        if (pause_edge) state_d = ST_PLAY;
      end
`endif
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Lives/level updates and the serve/reload pulses for the first SERVE cycle.
  always_comb begin
    lives_d  = lives_q;
    level_d  = level_q;
    reload_d = 1'b0;
    serve_d  = 1'b0;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          lives_d  = LIVES_W'(LIVES);
          level_d  = '0;
          reload_d = 1'b1;
          serve_d  = 1'b1;
        end
      end
      ST_MISS: begin
        lives_d = (lives_q > LIVES_W'(0)) ? (lives_q - LIVES_W'(1)) : '0;
        serve_d = (lives_q > LIVES_W'(1));
      end
      ST_CLEAR: begin
        if (level_q < LEVEL_W'(MAX_LEVEL)) level_d = level_q + LEVEL_W'(1);
        reload_d = 1'b1;
        serve_d  = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Output decode and divider control.
  always_comb begin
    div_en        = (state_q == ST_PLAY);
    div_clr       = (state_q == ST_SERVE) && launch_edge;
    div_val       = DIV_W'(step_div(TICK_DIV, level_q));
    game_over     = (state_q == ST_OVER);
    state         = state_q;
    lives         = lives_q;
    level         = level_q;
    bricks_reload = reload_q;
    ball_serve    = serve_q;
  end

  step_divider #(
    .DIV_W (DIV_W)
  ) u_step_divider (
    .clock  (clock),
    .reset  (reset),
    .enable (div_en),
    .clear  (div_clr),
    .div    (div_val),
    .tick   (step_tick)
  );

endmodule

// File: tb/tb_brick_game_ctrl.sv
// Self-checking bench for brick_game_ctrl with a small divider (TICK_DIV=8).
// Covers the PAUSE_EN option when the bench is built with that macro.
module tb_brick_game_ctrl;

  localparam int TICK_DIV  = 8;
  localparam int LIVES     = 3;
  localparam int MAX_LEVEL = 3;
  localparam logic [55:0] ALL = {56{1'b1}};

  logic        clock      = 1'b0;
  logic        reset      = 1'b0;
  logic        start_btn  = 1'b0;
  logic        launch_btn = 1'b0;
  logic        ball_lost  = 1'b0;
  logic [55:0] bricks     = {56{1'b1}};
`ifdef PAUSE_EN
  logic        pause_btn  = 1'b0;
`endif

  logic       step_tick;
  logic       bricks_reload;
  logic       ball_serve;
  logic [1:0] lives;
  logic [1:0] level;
  logic [2:0] state;
  logic       game_over;

  int tests    = 0;
  int failures = 0;

  // Spec-level model: state codes, lives, level, PLAY cycles since launch.
  int m_state  = 0;
  int m_lives  = LIVES;
  int m_level  = 0;
  int m_phase  = 0;
  bit m_reload = 0;
  bit m_serve  = 0;
  bit m_prev_start  = 0;
  bit m_prev_launch = 0;
`ifdef PAUSE_EN
  bit m_prev_pause  = 0;
`endif

  always #5 clock = ~clock;

  brick_game_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .LIVES     (LIVES),
    .MAX_LEVEL (MAX_LEVEL)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .start_btn     (start_btn),
    .launch_btn    (launch_btn),
`ifdef PAUSE_EN
    .pause_btn     (pause_btn),
`endif
    .bricks        (bricks),
    .ball_lost     (ball_lost),
    .step_tick     (step_tick),
    .bricks_reload (bricks_reload),
    .ball_serve    (ball_serve),
    .lives         (lives),
    .level         (level),
    .state         (state),
    .game_over     (game_over)
  );

  function automatic int exp_div(input int lvl);
    int d;
    d = TICK_DIV >> lvl;
    return (d < 1) ? 1 : d;
  endfunction

  function automatic int exp_tick();
    if (m_state != 2) return 0;
    return (((m_phase + 1) % exp_div(m_level)) == 0) ? 1 : 0;
  endfunction

  task automatic model_step();
    bit se, le, pe;
    if (!reset) begin
      m_state = 0; m_lives = LIVES; m_level = 0; m_phase = 0;
      m_reload = 0; m_serve = 0; m_prev_start = 0; m_prev_launch = 0;
`ifdef PAUSE_EN
      m_prev_pause = 0;
`endif
      return;
    end
    se = start_btn && !m_prev_start;
    le = launch_btn && !m_prev_launch;
    pe = 0;
`ifdef PAUSE_EN
    pe = pause_btn && !m_prev_pause;
    m_prev_pause = pause_btn;
`endif
    m_prev_start  = start_btn;
    m_prev_launch = launch_btn;
    m_reload = 0;
    m_serve  = 0;
    case (m_state)
      0, 5: if (se) begin
        m_lives = LIVES; m_level = 0; m_state = 1; m_reload = 1; m_serve = 1;
      end
      1: if (le) begin
        m_state = 2; m_phase = 0;
      end
      2: begin
        m_phase++;
        if (bricks == 0) m_state = 4;
        else if (ball_lost) m_state = 3;
        else if (pe) m_state = 6;
      end
      3: begin
        m_lives--;
        if (m_lives == 0) m_state = 5;
        else begin m_state = 1; m_serve = 1; end
      end
      4: begin
        if (m_level < MAX_LEVEL) m_level++;
        m_state = 1; m_reload = 1; m_serve = 1;
      end
      6: if (pe) m_state = 2;
      default: begin end
    endcase
  endtask

  task automatic check_output(input string name, input int actual, input int expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #2;
  endtask

  // Drive one cycle of inputs, then return them to the idle pattern.
  task automatic apply_stimulus(input bit s, input bit l, input bit lost, input logic [55:0] b);
    start_btn  = s;
    launch_btn = l;
    ball_lost  = lost;
    bricks     = b;
    cycle();
    start_btn  = 1'b0;
    launch_btn = 1'b0;
    ball_lost  = 1'b0;
    bricks     = ALL;
  endtask

  task automatic count_ticks(input int n, output int cnt, output int first);
    cnt = 0;
    first = -1;
    for (int i = 0; i < n; i++) begin
      if (step_tick) begin
        if (first < 0) first = i;
        cnt++;
      end
      cycle();
    end
  endtask

  // Model update on every clock edge and on asynchronous reset.
  initial forever begin
    @(posedge clock or negedge reset);
    model_step();
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clock);
    check_output("state", state, m_state);
    check_output("lives", lives, m_lives);
    check_output("level", level, m_level);
    check_output("step_tick", step_tick, exp_tick());
    check_output("bricks_reload", bricks_reload, m_reload);
    check_output("ball_serve", ball_serve, m_serve);
    check_output("game_over", game_over, (m_state == 5) ? 1 : 0);
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c, f;
    int lv_exp[4];
    lv_exp = '{2, 3, 3, 3};

    // Reset state
    repeat (3) @(posedge clock);
    #2;
    check_output("rst_state", state, 0);
    check_output("rst_lives", lives, 3);
    check_output("rst_level", level, 0);
    check_output("rst_tick", step_tick, 0);
    check_output("rst_reload", bricks_reload, 0);
    check_output("rst_serve", ball_serve, 0);
    check_output("rst_over", game_over, 0);
    reset = 1'b1;
    cycle();
    cycle();
    check_output("idle_hold", state, 0);

    // Start, serve pulses, launch, period-8 ticks
    apply_stimulus(1, 0, 0, ALL);
    check_output("serve_state", state, 1);
    check_output("serve_reload", bricks_reload, 1);
    check_output("serve_pulse", ball_serve, 1);
    cycle();
    check_output("serve_reload_end", bricks_reload, 0);
    check_output("serve_pulse_end", ball_serve, 0);
    apply_stimulus(1, 0, 0, ALL);
    check_output("start_in_serve", state, 1);
    apply_stimulus(0, 1, 0, ALL);
    check_output("play_state", state, 2);
    count_ticks(16, c, f);
    check_output("l0_first_tick", f, 7);
    check_output("l0_tick_count", c, 2);

    // Three misses down to game over
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(0, 0, 1, ALL);
      check_output("miss_state", state, 3);
      cycle();
      check_output("miss_lives", lives, 2 - i);
      if (i < 2) begin
        check_output("reserve_state", state, 1);
        check_output("reserve_pulse", ball_serve, 1);
        check_output("reserve_no_reload", bricks_reload, 0);
        apply_stimulus(0, 1, 0, ALL);
        repeat (3) cycle();
      end
    end
    check_output("over_state", state, 5);
    check_output("over_flag", game_over, 1);
    count_ticks(10, c, f);
    check_output("over_no_tick", c, 0);
    apply_stimulus(0, 1, 0, ALL);
    check_output("launch_in_over", state, 5);
    apply_stimulus(1, 0, 0, ALL);
    check_output("restart_lives", lives, 3);
    check_output("restart_level", level, 0);
    check_output("restart_state", state, 1);

    // Clear beats simultaneous ball loss
    apply_stimulus(0, 1, 0, ALL);
    repeat (3) cycle();
    apply_stimulus(0, 0, 1, '0);
    check_output("clear_state", state, 4);
    check_output("clear_lives", lives, 3);
    cycle();
    check_output("clear_serve_state", state, 1);
    check_output("clear_level", level, 1);
    check_output("clear_reload", bricks_reload, 1);
    check_output("clear_serve", ball_serve, 1);
    apply_stimulus(0, 1, 0, ALL);
    count_ticks(8, c, f);
    check_output("l1_first_tick", f, 3);
    check_output("l1_tick_count", c, 2);

    // Level saturation
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 0, 0, '0);
      cycle();
      check_output("sat_level", level, lv_exp[i]);
      apply_stimulus(0, 1, 0, ALL);
    end
    count_ticks(6, c, f);
    check_output("l3_first_tick", f, 0);
    check_output("l3_tick_count", c, 6);

    // Reset mid-PLAY
    repeat (2) cycle();
    reset = 1'b0;
    #1;
    check_output("midrst_state", state, 0);
    check_output("midrst_lives", lives, 3);
    check_output("midrst_level", level, 0);
    check_output("midrst_tick", step_tick, 0);
    repeat (2) cycle();
    reset = 1'b1;
    cycle();
    check_output("release_state", state, 0);
    check_output("release_reload", bricks_reload, 0);
    check_output("release_serve", ball_serve, 0);
    apply_stimulus(1, 0, 0, ALL);
    apply_stimulus(0, 1, 0, ALL);
    repeat (4) cycle();
`ifdef PAUSE_EN
    pause_btn = 1'b1;
    cycle();
    pause_btn = 1'b0;
    check_output("pause_state", state, 6);
    apply_stimulus(1, 0, 1, '0);
    check_output("pause_ignores", state, 6);
    check_output("pause_tick", step_tick, 0);
    cycle();
    pause_btn = 1'b1;
    cycle();
    pause_btn = 1'b0;
    check_output("resume_state", state, 2);
    count_ticks(3, c, f);
    check_output("resume_first_tick", f, 2);
    check_output("resume_tick_count", c, 1);
`else
    cycle();
    reset = 1'b0;
    #1;
    check_output("rst5_state", state, 0);
    check_output("rst5_tick", step_tick, 0);
    cycle();
    reset = 1'b1;
    cycle();
    apply_stimulus(1, 0, 0, ALL);
    apply_stimulus(0, 1, 0, ALL);
    count_ticks(8, c, f);
    check_output("after_rst_first_tick", f, 7);
    check_output("after_rst_tick_count", c, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule

// File: doc/brick_game_ctrl.md
Name: brick_game_ctrl

Overview:
Top-level game sequencer for the brick-breaker design. It owns the game state machine (idle, serve, play, miss, clear, game-over) and the lives and level counters. It generates the ball-advance enable tick, with a period that shrinks per level. It commands brick-field reload and ball re-serve, and monitors the 56-bit brick map and the ball-lost flag from the ball/score datapath.

Parameters:
TICK_DIV, 25000000, clock cycles per ball step at level 0 (2 Hz at 50 MHz).
LIVES, 3, lives granted at game start (1..3).
MAX_LEVEL, 3, highest level; the step divisor is TICK_DIV >> level.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start_btn  in  1  synchronous level; its rising edge starts a new game from IDLE or OVER
launch_btn  in  1  synchronous level; its rising edge launches the ball from SERVE
bricks  in  56  live brick map from the score block (1 = brick present)
ball_lost  in  1  ball passed the paddle row; sampled only in PLAY
step_tick  out  1  one-cycle ball-advance enable
bricks_reload  out  1  one-cycle pulse: reinitialise brick map to all ones
ball_serve  out  1  one-cycle pulse: place ball on paddle, direction up
lives  out  2  remaining lives
level  out  2  current level, 0..MAX_LEVEL
state  out  3  FSM state code, for debug and display
game_over  out  1  high while in OVER

Behaviour:
- Reset (async, active-low): state=IDLE, lives=LIVES, level=0. All pulse outputs 0, game_over=0, divider count 0, button edge registers 0.
- Edge detect: one register per button. An edge means current=1 and previous=0.
- State codes: IDLE=0, SERVE=1, PLAY=2, MISS=3, CLEAR=4, OVER=5, PAUSE=6 (present only with the option).
- IDLE or OVER, start edge: lives<=LIVES, level<=0, next state SERVE. bricks_reload and ball_serve are high for exactly the first cycle in SERVE.
- SERVE: step_tick held 0. Launch edge: PLAY, divider count cleared to 0.
- PLAY divider:
  - Count increments every cycle.
  - When count == div-1: step_tick=1 for that cycle and count wraps to 0.
  - div = max(1, TICK_DIV >> level). With div=1, step_tick is high every PLAY cycle.
  - The divider counts only in PLAY and holds its value elsewhere.
- PLAY exits:
  - bricks==0: go to CLEAR. This has priority over a simultaneous ball_lost.
  - Else ball_lost=1: go to MISS.
  - step_tick is 0 in the exit cycle's successor.
- MISS (1 cycle): lives decrements.
  - If lives was 1: lives=0, go to OVER, game_over=1.
  - Else go to SERVE with a ball_serve pulse; bricks are not reloaded.
- CLEAR (1 cycle): level increments, saturating at MAX_LEVEL. Go to SERVE with bricks_reload and ball_serve pulses. lives unchanged.
- OVER: game_over=1, step_tick=0. lives and level hold for display until a start edge.
- Button edges outside their accepting states are ignored and not queued.
- Reset asserted mid-operation: immediate return to IDLE values. No pulses are emitted on reset release.
- Width: lives and level are 2-bit with no wrap; decrement and increment are guarded as above.

Optional Feature:
PAUSE_EN.
- Defined: adds input pause_btn.
  - Its edge in PLAY goes to PAUSE; its edge in PAUSE returns to PLAY.
  - In PAUSE the divider count is frozen (not cleared), step_tick=0, and ball_lost and bricks are ignored.
  - A start edge in PAUSE is ignored.
- Undefined: no port, no PAUSE state; code 6 is unreachable.

Decomposition:
- Package brick_game_pkg holds:
  - state encoding constants/typedef;
  - NUM_BRICKS=56;
  - LIVES_W=2, LEVEL_W=2.
- One sub-module, step_divider (enable, clear, div input, tick output), instantiated once.
- The FSM, counters and edge detectors stay in brick_game_ctrl.

Test Plan:
1. TICK_DIV=8, LIVES=3; assert reset → state=0, lives=3, level=0, all pulses 0, game_over=0.
2. bricks=all ones; start edge → next cycle state=1 with bricks_reload=1 and ball_serve=1 for 1 cycle; launch edge → state=2, step_tick every 8th cycle (first on the 8th PLAY cycle).
3. Three ball_lost pulses in PLAY, each followed by a launch → lives 2, then 1, then 0; after the third, state=5, game_over=1, no further step_tick; a start edge restores lives=3, level=0.
4. bricks=0 and ball_lost=1 in the same PLAY cycle → CLEAR taken, lives unchanged, level=1, reload+serve pulses; after launch, step_tick period 4.
5. Repeat clears four times → level saturates at 3, period 1 (step_tick continuous); a further clear leaves level=3.
6. Assert reset mid-PLAY with count=5 → immediate state=0, count 0; with PAUSE_EN, pause at count=5 and resume → next step_tick after 3 more cycles.
